// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: merges ID/EX stall requests and sequences multi-cycle EX ops.
// Optional STALL_PERF_CNT_EN adds 32-bit ID/EX stall-cycle performance counters.
module pipe_stall_ctrl #(
    parameter int MC_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_id,
    input  logic            stallreq_ex,
    input  logic            ex_mc_start,
    input  logic [MC_W-1:0] ex_mc_cycles,
    output logic [5:0]      stall,
    output logic            mc_busy,
    output logic [MC_W-1:0] mc_cnt,
    output logic            mc_last
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0]     perf_id_stalls,
    output logic [31:0]     perf_ex_stalls
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [5:0] PAT_NONE = 6'b000000;
    localparam logic [5:0] PAT_ID   = 6'b000111;
    localparam logic [5:0] PAT_EX   = 6'b001111;

    state_t state;
    logic   start_ok;
    logic   ex_class;

    // A zero-length start is treated as no start at all.
    assign start_ok = (state == IDLE) && ex_mc_start && (ex_mc_cycles != '0);
    assign ex_class = (state == BUSY) || start_ok || stallreq_ex;

    always_comb begin
        stall   = PAT_NONE;
        mc_last = 1'b0;
        if (!rst) begin
            if (ex_class)
                stall = PAT_EX;
            else if (stallreq_id)
                stall = PAT_ID;
            mc_last = ((state == BUSY) && (mc_cnt == '0)) ||
                      (start_ok && (ex_mc_cycles == MC_W'(1)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mc_cnt  <= '0;
            mc_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok && (ex_mc_cycles != MC_W'(1))) begin
                        state   <= BUSY;
                        mc_cnt  <= ex_mc_cycles - MC_W'(2);
                        mc_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mc_cnt == '0) begin
                        state   <= IDLE;
                        mc_busy <= 1'b0;
                    end else begin
                        mc_cnt <= mc_cnt - MC_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    mc_cnt  <= '0;
                    mc_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef STALL_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_id_stalls <= '0;
            perf_ex_stalls <= '0;
        end else begin
            if (stall == PAT_ID)
                perf_id_stalls <= perf_id_stalls + 32'd1;
            if (stall == PAT_EX)
                perf_ex_stalls <= perf_ex_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl; perf-counter checks build only with STALL_PERF_CNT_EN.
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stallreq_id = 1'b0;
    logic       stallreq_ex = 1'b0;
    logic       ex_mc_start = 1'b0;
    logic [5:0] ex_mc_cycles = '0;
    logic [5:0] stall;
    logic       mc_busy;
    logic [5:0] mc_cnt;
    logic       mc_last;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_id_stalls;
    logic [31:0] perf_ex_stalls;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stall_ctrl #(.MC_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .stall        (stall),
        .mc_busy      (mc_busy),
        .mc_cnt       (mc_cnt),
        .mc_last      (mc_last)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_id_stalls (perf_id_stalls),
        .perf_ex_stalls (perf_ex_stalls)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Drive one cycle's inputs after the falling edge; outputs are then stable for checking.
    task automatic cyc(input logic r, input logic id, input logic ex,
                       input logic st, input logic [5:0] n);
        @(negedge clk);
        rst          = r;
        stallreq_id  = id;
        stallreq_ex  = ex;
        ex_mc_start  = st;
        ex_mc_cycles = n;
        #1;
    endtask

    initial begin
        // Reset overrides a pending ID request.
        cyc(1, 1, 0, 0, 0);
        check("rst_stall", stall, 6'b000000);
        cyc(1, 0, 1, 1, 6'd5);
        check("rst_stall_ex", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0);
        check("rst_busy", mc_busy, 1'b0);
        check("rst_cnt", mc_cnt, 6'd0);
        check("rst_stall_idle", stall, 6'b000000);
        check("rst_last", mc_last, 1'b0);

        // Single-cycle ID and EX requests.
        cyc(0, 1, 0, 0, 0);
        check("id_stall", stall, 6'b000111);
        cyc(0, 0, 0, 0, 0);
        check("id_release", stall, 6'b000000);
        cyc(0, 0, 1, 0, 0);
        check("ex_stall", stall, 6'b001111);
        check("ex_no_busy_last", mc_last, 1'b0);
        cyc(0, 1, 1, 0, 0);
        check("ex_over_id", stall, 6'b001111);
        cyc(0, 0, 0, 0, 0);
        check("ex_release", stall, 6'b000000);

        // N=5 sequence.
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, (k == 0), (k == 0) ? 6'd5 : 6'd0);
            check($sformatf("n5_stall_%0d", k), stall, 6'b001111);
            check($sformatf("n5_last_%0d", k), mc_last, (k == 4));
            check($sformatf("n5_busy_%0d", k), mc_busy, (k > 0));
            if (k > 0)
                check($sformatf("n5_cnt_%0d", k), mc_cnt, 6'(4 - k));
        end
        cyc(0, 0, 0, 0, 0);
        check("n5_end_stall", stall, 6'b000000);
        check("n5_end_busy", mc_busy, 1'b0);
        check("n5_end_last", mc_last, 1'b0);

        // N=0 is ignored.
        cyc(0, 0, 0, 1, 6'd0);
        check("n0_stall", stall, 6'b000000);
        check("n0_last", mc_last, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("n0_busy", mc_busy, 1'b0);

        // N=1: one stall cycle, never busy.
        cyc(0, 0, 0, 1, 6'd1);
        check("n1_stall", stall, 6'b001111);
        check("n1_last", mc_last, 1'b1);
        cyc(0, 0, 0, 0, 0);
        check("n1_busy", mc_busy, 1'b0);
        check("n1_after", stall, 6'b000000);

        // N=4 with concurrent ID request and an ignored second start.
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, (k <= 1), (k == 0) ? 6'd4 : 6'd9);
            check($sformatf("n4_stall_%0d", k), stall, 6'b001111);
            check($sformatf("n4_last_%0d", k), mc_last, (k == 3));
        end
        cyc(0, 1, 0, 0, 0);
        check("n4_id_after", stall, 6'b000111);
        check("n4_busy_after", mc_busy, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("n4_idle", stall, 6'b000000);

        // Reset in the middle of an N=10 sequence.
        cyc(0, 0, 0, 1, 6'd10);
        cyc(0, 0, 0, 0, 0);
        check("r10_cnt", mc_cnt, 6'd8);
        cyc(1, 0, 0, 0, 0);
        check("r10_stall_rst", stall, 6'b000000);
        cyc(0, 0, 0, 0, 0);
        check("r10_busy", mc_busy, 1'b0);
        check("r10_cnt0", mc_cnt, 6'd0);
        check("r10_stall", stall, 6'b000000);

        // Back-to-back N=2 sequences with no idle gap.
        cyc(0, 0, 0, 1, 6'd2);
        check("b2b_last0", mc_last, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("b2b_last1", mc_last, 1'b1);
        check("b2b_busy1", mc_busy, 1'b1);
        cyc(0, 0, 0, 1, 6'd2);
        check("b2b_stall2", stall, 6'b001111);
        check("b2b_last2", mc_last, 1'b0);
        check("b2b_busy2", mc_busy, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("b2b_last3", mc_last, 1'b1);
        check("b2b_busy3", mc_busy, 1'b1);
        cyc(0, 0, 0, 0, 0);
        check("b2b_end", stall, 6'b000000);

        // Maximum length loads N-2.
        cyc(0, 0, 0, 1, 6'd63);
        cyc(0, 0, 0, 0, 0);
        check("n63_cnt", mc_cnt, 6'd61);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("n63_rst_busy", mc_busy, 1'b0);

`ifdef STALL_PERF_CNT_EN
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("perf_clr_id", perf_id_stalls, 32'd0);
        check("perf_clr_ex", perf_ex_stalls, 32'd0);
        for (int k = 0; k < 3; k++)
            cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 6'd5);
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("perf_id", perf_id_stalls, 32'd3);
        check("perf_ex", perf_ex_stalls, 32'd5);
        @(negedge clk);
        stallreq_ex = 1'b1;
        force dut.perf_ex_stalls = 32'hFFFF_FFFF;
        #1;
        release dut.perf_ex_stalls;
        cyc(0, 0, 0, 0, 0);
        check("perf_wrap", perf_ex_stalls, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
